seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Display back-end of the 7-segment game. Consumes the four 5-bit message codes, `stop_flag` and `end_flag` produced by the game FSM and time-multiplexes them onto a 4-digit common-anode display. Provides frame-coherent latching, per-digit ghost blanking, decimal-point marking of stopped digits and whole-display blinking while the game-over flag is raised.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot; minimum 2.
- `BLINK_FRAMES`, default 64: frames per blink half-period; minimum 1.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `message0`..`message3`  in  5 each  display codes; `message0` goes to the rightmost digit, `an[0]`.
- `stop_flag`  in  4  bit i = digit i stopped.
- `end_flag`  in  1  game over; the display blinks while it is high.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  4  digit enables, active-low, one-hot-low when lit.

## Operation
- Slot counter `cnt` runs 0..`SCAN_DIV`-1. The digit index `idx` (0..3) advances on wrap. One frame is 4·`SCAN_DIV` cycles.
- **Frame latch.** At `cnt`==0 with `idx`==0, all four messages, `stop_flag` and `end_flag` are captured into shadow registers. All displayed data comes only from the shadows, so there is no tearing mid-frame.
- **Ghost blanking.** During `cnt`==0 of every slot, `an`=4'hF. For `cnt`≥1, `an` = ~(1<<`idx`).
- **Segment output.** `seg` = decode(shadow message[`idx`]). `dp` = ~shadow_stop[`idx`].
- **Code map.** 0–9 are digits; 10–15 are A–F; 16 is blank; 17 is dash (g only); 18 P, 19 L, 20 U, 21 n, 22 o, 23 r, 24 H, 25 E. Codes 26–31 are blank.
- **Blink.** A frame counter counts 0..`BLINK_FRAMES`-1. On wrap, the phase toggles.
  - While shadow_end=1 and phase=off: `an`=4'hF for the whole frame.
  - While shadow_end=0: the phase is forced to on and the frame counter is held at 0. Blinking therefore always starts with a full on half-period.
- **Reset.** While low: `seg`=7'h7F, `dp`=1, `an`=4'hF, `cnt`=`idx`=0, frame counter=0, phase=on. Shadows = code 16 (blank), stop=0, end=0.
- **Reset release.** The first frame latch occurs on the first clock edge after release.
- **Reset mid-frame.** Outputs go dark immediately, because the reset is asynchronous.

## Timing
- All outputs are registered; output = f(state before edge), one-cycle pipeline from the counters.
- Input to display latency: a change is visible no later than 4·`SCAN_DIV`+1 cycles after it, i.e. from the next frame start plus one cycle.
- Inputs are sampled only at the latch cycle. Glitches between latches are ignored.
- If `end_flag` falls during the off phase, the display resumes at the next frame latch.

## Structure
- Package `seg7_pkg` holds:
  - code constants `CODE_BLANK`=16, `CODE_DASH`=17 and the letter codes;
  - `SEG_BLANK`=7'h7F;
  - the code→segment function or constant table.
  - The FSM shares these codes.
- Sub-module `seg7_decode` is a combinational 5-bit code → 7-bit active-low segment decoder.
- The top module contains the scan counter, digit index, frame latch and blink counter/phase, with the output registers.

## Test plan
Run with `SCAN_DIV`=4 and `BLINK_FRAMES`=2.
- **Reset.** Hold `reset`=0 for 5 cycles with arbitrary inputs -> `an`=4'hF, `seg`=7'h7F, `dp`=1 throughout. Release -> first lit digit is `an`=4'b1110.
- **Basic scan.** messages 0,1,8,17, stop=0 -> per slot: one blank cycle, then three cycles each of:
  - `an`=1110, `seg`=7'h40
  - `an`=1101, `seg`=7'h79
  - `an`=1011, `seg`=7'h00
  - `an`=0111, `seg`=7'h3F

  with `dp`=1.
- **Frame coherence.** Change `message0` from 0 to 5 mid-frame, while digit 2 is lit -> digit 0 still shows 7'h40 until the next frame, then 7'h12.
- **Stop marking.** `stop_flag`=4'b0101 -> `dp`=0 only while `an`=1110 or 1011.
- **Blink.** Raise `end_flag` -> 2 frames lit, 2 frames with `an`=4'hF, and so on.
  - Drop `end_flag` during an off phase -> lit again from the next frame.
  - Raising it again starts with 2 lit frames.
- **Undefined codes and async reset.** Code 28 on any digit -> `seg`=7'h7F. Assert `reset` between edges -> outputs go dark before the next clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: display codes, segment patterns and the code-to-segment table
// shared by the game FSM and the scan driver.
package seg7_pkg;
   localparam logic [4:0] CODE_BLANK = 5'd16;
   localparam logic [4:0] CODE_DASH  = 5'd17;
   localparam logic [4:0] CODE_P     = 5'd18;
   localparam logic [4:0] CODE_L     = 5'd19;
   localparam logic [4:0] CODE_U     = 5'd20;
   localparam logic [4:0] CODE_N     = 5'd21;
   localparam logic [4:0] CODE_O     = 5'd22;
   localparam logic [4:0] CODE_R     = 5'd23;
   localparam logic [4:0] CODE_H     = 5'd24;
   localparam logic [4:0] CODE_E     = 5'd25;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef struct packed {
      logic [3:0][4:0] msg;
      logic [3:0]      stop;
      logic            fin;
   } frame_t;

   localparam frame_t FRAME_RESET = '{msg: {4{CODE_BLANK}}, stop: 4'h0, fin: 1'b0};

   // Patterns are {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] seg7_of(input logic [4:0] code);
      case (code)
         5'd0:       return 7'h40;
         5'd1:       return 7'h79;
         5'd2:       return 7'h24;
         5'd3:       return 7'h30;
         5'd4:       return 7'h19;
         5'd5:       return 7'h12;
         5'd6:       return 7'h02;
         5'd7:       return 7'h78;
         5'd8:       return 7'h00;
         5'd9:       return 7'h10;
         5'd10:      return 7'h08;
         5'd11:      return 7'h03;
         5'd12:      return 7'h46;
         5'd13:      return 7'h21;
         5'd14:      return 7'h06;
         5'd15:      return 7'h0E;
         CODE_DASH:  return 7'h3F;
         CODE_P:     return 7'h0C;
         CODE_L:     return 7'h47;
         CODE_U:     return 7'h41;
         CODE_N:     return 7'h2B;
         CODE_O:     return 7'h23;
         CODE_R:     return 7'h2F;
         CODE_H:     return 7'h09;
         CODE_E:     return 7'h06;
         default:    return SEG_BLANK;
      endcase
   endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 5-bit display code to active-low segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [4:0] i_code,
   output logic [6:0] o_seg
);
   assign o_seg = seg7_of(i_code);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-latched 4-digit common-anode scanner with ghost
// blanking, stop-digit decimal points and game-over blinking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] message0,
   input  logic [4:0] message1,
   input  logic [4:0] message2,
   input  logic [4:0] message3,
   input  logic [3:0] stop_flag,
   input  logic       end_flag,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [FW-1:0] r_frm;
   logic          r_phase;
   frame_t        r_shadow;
   frame_t        w_frame;
   logic          w_slot_end;
   logic          w_latch;
   logic          w_blink_run;
   logic          w_dark;
   logic [6:0]    w_seg;

   assign w_frame     = {message3, message2, message1, message0, stop_flag, end_flag};
   assign w_slot_end  = r_cnt == CNT_LAST;
   assign w_latch     = r_cnt == '0 && r_idx == 2'd0;
   // Blinking only counts once game-over was already latched last frame, so it always starts lit.
   assign w_blink_run = end_flag && r_shadow.fin;
   assign w_dark      = r_cnt == '0 || (r_shadow.fin && !r_phase);

   seg7_decode u_dec (
      .i_code (r_shadow.msg[r_idx]),
      .o_seg  (w_seg)
   );

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_frm    <= '0;
         r_phase  <= 1'b1;
         r_shadow <= FRAME_RESET;
         seg      <= SEG_BLANK;
         dp       <= 1'b1;
         an       <= 4'hF;
      end else begin
         r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
         if (w_slot_end)
            r_idx <= r_idx + 1'b1;
         if (w_latch) begin
            r_shadow <= w_frame;
            r_frm    <= w_blink_run && r_frm != FRM_LAST ? r_frm + 1'b1 : '0;
            r_phase  <= !w_blink_run || (r_frm == FRM_LAST ? !r_phase : r_phase);
         end
         seg <= w_seg;
         dp  <= ~r_shadow.stop[r_idx];
         an  <= w_dark ? 4'hF : ~(4'b0001 << r_idx);
      end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: frame-level scoreboard bench for seg7_scan_driver
// with SCAN_DIV=4 and BLINK_FRAMES=2.
module tb_seg7_scan_driver;
   localparam int SD = 4;
   localparam int BF = 2;
   localparam int FR = 4 * SD;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       full;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] message0 = '0, message1 = '0, message2 = '0, message3 = '0;
   logic [3:0] stop_flag = '0;
   logic       end_flag = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   exp_t       q[$];
   logic [6:0] ref_seg [0:31];
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk       (clk),
      .reset     (reset),
      .message0  (message0),
      .message1  (message1),
      .message2  (message2),
      .message3  (message3),
      .stop_flag (stop_flag),
      .end_flag  (end_flag),
      .seg       (seg),
      .dp        (dp),
      .an        (an)
   );

   task automatic init_ref();
      logic [6:0] t [0:25];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
            7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h7F, 7'h3F, 7'h0C, 7'h47,
            7'h41, 7'h2B, 7'h23, 7'h2F, 7'h09, 7'h06};
      for (int i = 0; i < 32; i++) ref_seg[i] = i < 26 ? t[i] : 7'h7F;
   endtask

   // Expected outputs for the frame latched at the next edge, one entry per cycle.
   task automatic push_frame(input logic [3:0][4:0] m, input logic [3:0] st, input bit lit, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         exp_t e;
         int   d;
         d      = c / SD;
         e.full = lit && (c % SD != 0);
         e.an   = e.full ? ~(4'b0001 << d) : 4'hF;
         e.seg  = ref_seg[m[d]];
         e.dp   = ~st[d];
         q.push_back(e);
      end
   endtask

   task automatic run_cycles(input string name, input int ncyc, input int mid_at, input logic [4:0] mid_m0);
      for (int c = 0; c < ncyc; c++) begin
         exp_t e;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL %s cyc %0d: scoreboard empty", name, c);
         end else begin
            e = q.pop_front();
            if (e.full ? ({an, seg, dp} !== {e.an, e.seg, e.dp}) : (an !== e.an)) begin
               failures++;
               $display("FAIL %s cyc %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                        name, c, an, seg, dp, e.an, e.seg, e.dp);
            end
         end
         if (c == mid_at) message0 = mid_m0;
      end
   endtask

   task automatic drive(input logic [3:0][4:0] m, input logic [3:0] st, input logic ef);
      {message3, message2, message1, message0} = m;
      stop_flag = st;
      end_flag  = ef;
   endtask

   task automatic frame(input string name, input logic [3:0][4:0] m, input logic [3:0] st,
                        input logic ef, input bit lit);
      drive(m, st, ef);
      push_frame(m, st, lit, FR);
      run_cycles(name, FR, -1, 5'd0);
   endtask

   task automatic check_dark(input string name);
      checks++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
         failures++;
         $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1", name, an, seg, dp);
      end
   endtask

   task automatic test_reset();
      drive({5'd3, 5'd9, 5'd2, 5'd7}, 4'b1111, 1'b1);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_dark("reset_hold");
      end
      drive({5'd17, 5'd8, 5'd1, 5'd0}, 4'b0000, 1'b0);
      reset = 1'b1;
   endtask

   task automatic test_basic_scan();
      frame("scan0", {5'd17, 5'd8, 5'd1, 5'd0}, 4'b0000, 1'b0, 1'b1);
      frame("scan1", {5'd17, 5'd8, 5'd1, 5'd0}, 4'b0000, 1'b0, 1'b1);
   endtask

   task automatic test_frame_coherence();
      drive({5'd17, 5'd8, 5'd1, 5'd0}, 4'b0000, 1'b0);
      push_frame({5'd17, 5'd8, 5'd1, 5'd0}, 4'b0000, 1'b1, FR);
      run_cycles("coh_old", FR, 9, 5'd5);
      frame("coh_new", {5'd17, 5'd8, 5'd1, 5'd5}, 4'b0000, 1'b0, 1'b1);
   endtask

   task automatic test_stop();
      frame("stop", {5'd17, 5'd8, 5'd1, 5'd0}, 4'b0101, 1'b0, 1'b1);
   endtask

   task automatic test_codes();
      frame("letters", {5'd25, 5'd19, 5'd18, 5'd10}, 4'b0000, 1'b0, 1'b1);
      frame("letters2", {5'd24, 5'd23, 5'd22, 5'd21}, 4'b1010, 1'b0, 1'b1);
      frame("undef", {5'd16, 5'd26, 5'd31, 5'd28}, 4'b0000, 1'b0, 1'b1);
   endtask

   task automatic test_blink();
      bit ef  [13] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
      bit lit [13] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1};
      for (int f = 0; f < 13; f++)
         frame($sformatf("blink%0d", f), {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0010, ef[f], lit[f]);
   endtask

   task automatic test_async_reset();
      drive({5'd6, 5'd7, 5'd9, 5'd2}, 4'b0011, 1'b0);
      push_frame({5'd6, 5'd7, 5'd9, 5'd2}, 4'b0011, 1'b1, 6);
      run_cycles("pre_async", 6, -1, 5'd0);
      #1 reset = 1'b0;
      #1 check_dark("async_reset");
      @(negedge clk);
      check_dark("async_hold");
      reset = 1'b1;
      frame("post_reset", {5'd6, 5'd7, 5'd9, 5'd2}, 4'b0011, 1'b0, 1'b1);
   endtask

   initial begin
      init_ref();
      test_reset();
      test_basic_scan();
      test_frame_coherence();
      test_stop();
      test_codes();
      test_blink();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
